// File: rtl/fastica_pkg.sv
// Shared definitions for the FastICA datapath blocks.
//   DW/FRAC/N     : element width, fractional bits (Q12.13), matrix order
//   sdc_state_t   : control states of the symmetric decorrelation step
//   sat_dw()      : clamp a wide signed value to DW bits, flag overflow
//   elem()        : flat element index (r*N+c) of a 4x4 packed matrix
package fastica_pkg;

  localparam int DW   = 26;
  localparam int FRAC = 13;
  localparam int N    = 4;

  localparam int MW   = N * N * DW;        // packed matrix width
  localparam int SW   = 2 * DW + 2;        // dot-product accumulator width
  localparam int CWW  = SW - FRAC;         // C*W element after the Q13 rescale
  localparam int YW   = CWW + 2;           // update expression width

  typedef enum logic [1:0] {IDLE, COMP, DONE} sdc_state_t;

  typedef struct packed {
    logic [DW-1:0] val;
    logic          ovf;
  } sat_res_t;

  function automatic sat_res_t sat_dw(input logic signed [YW-1:0] v);
    logic signed [YW-1:0] max_v;
    logic signed [YW-1:0] min_v;
    sat_res_t             res;
    max_v   = {{(YW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    min_v   = {{(YW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    res.val = v[DW-1:0];
    res.ovf = 1'b0;
    if (v > max_v) begin
      res.val = max_v[DW-1:0];
      res.ovf = 1'b1;
    end else if (v < min_v) begin
      res.val = min_v[DW-1:0];
      res.ovf = 1'b1;
    end
    return res;
  endfunction

  // Only N=4 is supported, so the flat index is just {r,c}.
  function automatic logic [3:0] elem(input logic [1:0] r, input logic [1:0] c);
    return {r, c};
  endfunction

endpackage

// File: rtl/sdc_dot4.sv
// Combinational 4-term signed dot product with Q13 rescale.
//   c_row : row of C, element k at [k*DW +: DW]
//   w_col : column of W, element k at [k*DW +: DW]
//   cw    : (sum_k c_row[k]*w_col[k]) >>> FRAC, floor rounding
module sdc_dot4
  import fastica_pkg::*;
(
  input  logic        [N*DW-1:0] c_row,
  input  logic        [N*DW-1:0] w_col,
  output logic signed [CWW-1:0]  cw
);

  logic signed [SW-1:0] acc;

  always_comb begin
    logic signed [2*DW-1:0] a_k;
    logic signed [2*DW-1:0] b_k;
    logic signed [2*DW-1:0] p_k;
    acc = '0;
    a_k = '0;
    b_k = '0;
    p_k = '0;
    for (int k = 0; k < N; k++) begin
      a_k = {{DW{c_row[k*DW+DW-1]}}, c_row[k*DW +: DW]};
      b_k = {{DW{w_col[k*DW+DW-1]}}, w_col[k*DW +: DW]};
      p_k = a_k * b_k;
      acc = acc + {{2{p_k[2*DW-1]}}, p_k};
    end
  end

  // Dropping the low FRAC bits of a two's complement value is an
  // arithmetic shift that rounds toward -inf.
  assign cw = acc[SW-1:FRAC];

endmodule

// File: rtl/symm_decor_step.sv
// One FastICA symmetric decorrelation iteration: W_new = 1.5*W - 0.5*(C*W).
// One output element per cycle through a shared dot-product unit.
//   clk_sdc, rst_sdc : clock, synchronous active-high reset
//   start_sdc        : start request, sampled only in IDLE
//   w_in, c_in       : W and C = W*W^T (Q13), element (r,c) at [(r*N+c)*DW +: DW]
//   busy             : high from COMP entry through the DONE cycle
//   done             : one-cycle pulse, w_out valid from this cycle
//   sat              : some element of the current w_out was clamped
//   w_out            : W_new, held until the next DONE
module symm_decor_step
  import fastica_pkg::*;
(
  input  logic          clk_sdc,
  input  logic          rst_sdc,
  input  logic          start_sdc,
  input  logic [MW-1:0] w_in,
  input  logic [MW-1:0] c_in,
  output logic          busy,
  output logic          done,
  output logic          sat,
  output logic [MW-1:0] w_out
);

  sdc_state_t    state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [MW-1:0] w_cap_q, w_cap_d;
  logic [MW-1:0] c_cap_q, c_cap_d;
  logic [MW-1:0] shadow_q, shadow_d;
  logic [MW-1:0] w_out_q, w_out_d;
  logic          sat_acc_q, sat_acc_d;
  logic          sat_q, sat_d;

  logic [1:0]           r_sel, c_sel;
  logic [N*DW-1:0]      c_row, w_col;
  logic signed [CWW-1:0] cw;
  logic signed [DW-1:0] w_rc;
  logic signed [YW-1:0] w_ext, cw_ext, diff, y;
  sat_res_t             y_sat;

  // ---- operand select: row r of C, column c of W ----
  assign r_sel = idx_q[3:2];
  assign c_sel = idx_q[1:0];

  always_comb begin
    c_row = '0;
    w_col = '0;
    for (int k = 0; k < N; k++) begin
      c_row[k*DW +: DW] = c_cap_q[int'(elem(r_sel, 2'(k)))*DW +: DW];
      w_col[k*DW +: DW] = w_cap_q[int'(elem(2'(k), c_sel))*DW +: DW];
    end
  end

  sdc_dot4 u_dot4 (
    .c_row (c_row),
    .w_col (w_col),
    .cw    (cw)
  );

  // ---- update y = w + (w - cw)/2, then clamp to DW bits ----
  assign w_rc   = w_cap_q[int'(idx_q)*DW +: DW];
  assign w_ext  = {{(YW-DW){w_rc[DW-1]}}, w_rc};
  assign cw_ext = {{(YW-CWW){cw[CWW-1]}}, cw};
  assign diff   = w_ext - cw_ext;
  assign y      = w_ext + (diff >>> 1);
  assign y_sat  = sat_dw(y);

  // ---- control and result registers ----
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    w_cap_d   = w_cap_q;
    c_cap_d   = c_cap_q;
    shadow_d  = shadow_q;
    w_out_d   = w_out_q;
    sat_acc_d = sat_acc_q;
    sat_d     = sat_q;
    case (state_q)
      IDLE: begin
        if (start_sdc) begin
          w_cap_d   = w_in;
          c_cap_d   = c_in;
          sat_acc_d = 1'b0;
          idx_d     = 4'd0;
          state_d   = COMP;
        end
      end
      COMP: begin
        shadow_d[int'(idx_q)*DW +: DW] = y_sat.val;
        sat_acc_d = sat_acc_q | y_sat.ovf;
        idx_d     = idx_q + 4'd1;
        // Publish together with the last element so w_out and sat are
        // already valid during the DONE cycle.
        if (idx_q == 4'd15) begin
          w_out_d = shadow_d;
          sat_d   = sat_acc_d;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sdc) begin
    if (rst_sdc) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      shadow_q  <= '0;
      w_out_q   <= '0;
      sat_acc_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      w_out_q   <= w_out_d;
      sat_acc_q <= sat_acc_d;
      sat_q     <= sat_d;
    end
  end

  // Captured operands are only read after a start, so they need no reset.
  always_ff @(posedge clk_sdc) begin
    w_cap_q <= w_cap_d;
    c_cap_q <= c_cap_d;
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign sat   = sat_q;
  assign w_out = w_out_q;

endmodule

// File: tb/tb_symm_decor_step.sv
module tb_symm_decor_step;
  import fastica_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [MW-1:0] w_in, c_in, w_out;
  logic          busy, done, sat;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  symm_decor_step dut (
    .clk_sdc   (clk),
    .rst_sdc   (rst),
    .start_sdc (start),
    .w_in      (w_in),
    .c_in      (c_in),
    .busy      (busy),
    .done      (done),
    .sat       (sat),
    .w_out     (w_out)
  );

  typedef struct {
    string         name;
    logic [MW-1:0] w;
    logic [MW-1:0] c;
    logic [MW-1:0] exp_w;
    logic          exp_sat;
  } vec_t;

  task automatic chk(input string nm, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] diag(input logic [DW-1:0] d);
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[(i*N+i)*DW +: DW] = d;
    return m;
  endfunction

  // C = (W*W^T) >>> 13
  function automatic logic [MW-1:0] wwt(input logic [MW-1:0] w);
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        longint acc;
        longint sh;
        acc = 0;
        for (int k = 0; k < N; k++) begin
          logic signed [DW-1:0] a, b;
          a = w[(r*N+k)*DW +: DW];
          b = w[(j*N+k)*DW +: DW];
          acc += longint'(a) * longint'(b);
        end
        sh = acc >>> FRAC;
        m[(r*N+j)*DW +: DW] = sh[DW-1:0];
      end
    end
    return m;
  endfunction

  function automatic void golden(input logic [MW-1:0] w, input logic [MW-1:0] c,
                                 output logic [MW-1:0] o, output logic s);
    o = '0;
    s = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int cc = 0; cc < N; cc++) begin
        longint acc;
        longint cwv;
        longint wv;
        longint y;
        logic signed [DW-1:0] wrc;
        acc = 0;
        for (int k = 0; k < N; k++) begin
          logic signed [DW-1:0] ce, we;
          ce = c[(r*N+k)*DW +: DW];
          we = w[(k*N+cc)*DW +: DW];
          acc += longint'(ce) * longint'(we);
        end
        cwv = acc >>> FRAC;
        wrc = w[(r*N+cc)*DW +: DW];
        wv  = longint'(wrc);
        y   = wv + ((wv - cwv) >>> 1);
        if (y > 64'sd33554431) begin
          y = 64'sd33554431;
          s = 1'b1;
        end else if (y < -64'sd33554432) begin
          y = -64'sd33554432;
          s = 1'b1;
        end
        o[(r*N+cc)*DW +: DW] = y[DW-1:0];
      end
    end
  endfunction

  // Start a run, scramble the inputs right after capture, wait for done.
  task automatic run(input logic [MW-1:0] w, input logic [MW-1:0] c,
                     output logic [MW-1:0] got_w, output logic got_sat,
                     output int lat, output int bcnt);
    lat     = 0;
    bcnt    = 0;
    got_w   = '0;
    got_sat = 1'b0;
    @(negedge clk);
    w_in  = w;
    c_in  = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w_in  = ~w;
    c_in  = ~c;
    for (int n = 1; n <= 40; n++) begin
      if (busy) bcnt++;
      if (done) begin
        lat     = n;
        got_w   = w_out;
        got_sat = sat;
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [DW-1:0] rnd(input int lim);
    int v;
    v = int'($urandom_range(2 * lim)) - lim;
    return v[DW-1:0];
  endfunction

  initial begin
    vec_t          vecs [4];
    logic [MW-1:0] gw, ew, rw;
    logic          gs, es;
    int            lat, bcnt, dcount, first_done;
    logic          busy_after;

    vecs[0] = '{"identity",   diag(26'd8192),     diag(26'd8192),  diag(26'd8192),            1'b0};
    vecs[1] = '{"overshoot",  diag(26'd16384),    diag(26'd32768), diag(-26'sd8192),          1'b0};
    vecs[2] = '{"saturation", diag(26'd33554431), '0,              diag(26'd33554431),        1'b1};
    vecs[3] = '{"sat_clear",  diag(26'd8192),     diag(26'd8192),  diag(26'd8192),            1'b0};

    rst   = 1'b1;
    start = 1'b0;
    w_in  = '0;
    c_in  = '0;
    repeat (3) @(negedge clk);
    chk("reset busy",  MW'(busy),  '0);
    chk("reset done",  MW'(done),  '0);
    chk("reset sat",   MW'(sat),   '0);
    chk("reset w_out", w_out,      '0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run(vecs[i].w, vecs[i].c, gw, gs, lat, bcnt);
      chk({vecs[i].name, " latency"}, MW'(lat),  MW'(17));
      chk({vecs[i].name, " busy"},    MW'(bcnt), MW'(17));
      chk({vecs[i].name, " w_out"},   gw,        vecs[i].exp_w);
      chk({vecs[i].name, " sat"},     MW'(gs),   MW'(vecs[i].exp_sat));
    end

    // Start pulses during COMP (cycle 3) and DONE (cycle 17) are ignored.
    @(negedge clk);
    w_in  = diag(26'd16384);
    c_in  = diag(26'd32768);
    start = 1'b1;
    @(negedge clk);
    dcount     = 0;
    first_done = 0;
    busy_after = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      start = (n == 3) || (n == 17);
      if (done) begin
        dcount++;
        if (first_done == 0) first_done = n;
      end
      if (n == 18) busy_after = busy;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignored start done count", MW'(dcount),     MW'(1));
    chk("ignored start latency",    MW'(first_done), MW'(17));
    chk("ignored start idle after", MW'(busy_after), '0);
    chk("ignored start w_out",      w_out,           diag(-26'sd8192));

    // Reset in the middle of a run discards it.
    @(negedge clk);
    w_in  = diag(26'd8192);
    c_in  = diag(26'd8192);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    dcount = 0;
    for (int n = 1; n <= 30; n++) begin
      if (n == 5) rst = 1'b1;
      if (n == 6) begin
        chk("midreset busy",  MW'(busy), '0);
        chk("midreset w_out", w_out,     '0);
        rst = 1'b0;
      end
      if (done) dcount++;
      @(negedge clk);
    end
    chk("midreset no done", MW'(dcount), '0);
    run(diag(26'd8192), diag(26'd8192), gw, gs, lat, bcnt);
    chk("after reset latency", MW'(lat), MW'(17));
    chk("after reset w_out",   gw,       diag(26'd8192));
    chk("after reset sat",     MW'(gs),  '0);

    // Random matrices against the reference arithmetic.
    for (int it = 0; it < 500; it++) begin
      int lim;
      lim = (it % 2 == 1) ? 131072 : 16384;
      rw  = '0;
      for (int e = 0; e < N*N; e++) rw[e*DW +: DW] = rnd(lim);
      golden(rw, wwt(rw), ew, es);
      run(rw, wwt(rw), gw, gs, lat, bcnt);
      chk($sformatf("rand%0d latency", it), MW'(lat), MW'(17));
      chk($sformatf("rand%0d w_out", it),   gw,       ew);
      chk($sformatf("rand%0d sat", it),     MW'(gs),  MW'(es));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
